// File: rtl/uart_tx_ser.sv
// UART transmitter: serializes one word per handshake as start, LSB-first data,
// optional parity and one or two stop bits, paced by a 16x baud enable.
module uart_tx_ser #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce_16,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              new_tx_data,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              two_stop,
    output logic              tx_busy,
    output logic              ser_out
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt16_reg, cnt16_next;
    logic [2:0]        bitcnt_reg, bitcnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              par_bit_reg, par_bit_next;
    logic              par_en_reg, par_en_next;
    logic              two_stop_reg, two_stop_next;
    logic              stop2_reg, stop2_next;
    logic              busy_reg, busy_next;
    logic              ser_reg, ser_next;

    // Parity is folded at acceptance, since the data bits are shifted out later.
    logic [DATA_W-1:0] par_chain;
    assign par_chain[0] = tx_data[0];
    generate
        for (genvar gi = 1; gi < DATA_W; gi++) begin : g_par
            assign par_chain[gi] = par_chain[gi-1] ^ tx_data[gi];
        end
    endgenerate

    logic bit_end;
    assign bit_end = ce_16 && (cnt16_reg == 4'd15);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt16_reg    <= '0;
            bitcnt_reg   <= '0;
            shift_reg    <= '0;
            par_bit_reg  <= 1'b0;
            par_en_reg   <= 1'b0;
            two_stop_reg <= 1'b0;
            stop2_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            ser_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt16_reg    <= cnt16_next;
            bitcnt_reg   <= bitcnt_next;
            shift_reg    <= shift_next;
            par_bit_reg  <= par_bit_next;
            par_en_reg   <= par_en_next;
            two_stop_reg <= two_stop_next;
            stop2_reg    <= stop2_next;
            busy_reg     <= busy_next;
            ser_reg      <= ser_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt16_next    = cnt16_reg;
        bitcnt_next   = bitcnt_reg;
        shift_next    = shift_reg;
        par_bit_next  = par_bit_reg;
        par_en_next   = par_en_reg;
        two_stop_next = two_stop_reg;
        stop2_next    = stop2_reg;
        busy_next     = busy_reg;
        ser_next      = ser_reg;

        if (state_reg != IDLE && ce_16) begin
            cnt16_next = cnt16_reg + 4'd1;
        end

        case (state_reg)
            IDLE: begin
                if (new_tx_data && !busy_reg) begin
                    shift_next    = tx_data;
                    par_bit_next  = par_chain[DATA_W-1] ^ parity_odd;
                    par_en_next   = parity_en;
                    two_stop_next = two_stop;
                    stop2_next    = 1'b0;
                    cnt16_next    = '0;
                    bitcnt_next   = '0;
                    busy_next     = 1'b1;
                    ser_next      = 1'b0;
                    state_next    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    ser_next   = shift_reg[0];
                    shift_next = shift_reg >> 1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bitcnt_reg == LAST_BIT) begin
                        if (par_en_reg) begin
                            ser_next   = par_bit_reg;
                            state_next = PARITY;
                        end else begin
                            ser_next   = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        ser_next    = shift_reg[0];
                        shift_next  = shift_reg >> 1;
                        bitcnt_next = bitcnt_reg + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    ser_next   = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // A second stop bit is just another 16 pulses of line-high.
                    if (two_stop_reg && !stop2_reg) begin
                        stop2_next = 1'b1;
                    end else begin
                        stop2_next = 1'b0;
                        busy_next  = 1'b0;
                        ser_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                ser_next   = 1'b1;
            end
        endcase
    end

    assign tx_busy = busy_reg;
    assign ser_out = ser_reg;

endmodule

// File: tb/tb_uart_tx_ser.sv
// Bench for uart_tx_ser: directed requests feed an expected-frame queue that a
// ce_16-counting line decoder pops and checks bit by bit.
module tb_uart_tx_ser;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ce_16 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       new_tx_data = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       two_stop = 1'b0;
    logic       tx_busy;
    logic       ser_out;

    uart_tx_ser #(.DATA_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .ce_16       (ce_16),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .two_stop    (two_stop),
        .tx_busy     (tx_busy),
        .ser_out     (ser_out)
    );

    typedef struct {
        logic [7:0] data;
        logic       pen;
        logic       podd;
        logic       two;
    } frame_t;

    frame_t exp_q[$];
    frame_t cur;

    int checks = 0;
    int failures = 0;
    int frames_started = 0;
    int frames_done = 0;
    int mon_pc = 0;
    int mon_total = 0;
    int gap = 100;
    bit mon_busy = 1'b0;

    initial forever #5 clock = ~clock;

    // ce_16 once every 4 clocks, changed just after the active edge
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clock);
            #1;
            ph = (ph + 1) % 4;
            ce_16 = (ph == 0);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input frame_t f, input int idx);
        logic [7:0] d;
        d = f.data;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9 && f.pen) return (^d) ^ f.podd;
        return 1'b1;
    endfunction

    // Line decoder: mon_pc counts ce_16 pulses consumed since the start edge.
    always @(negedge clock) begin
        if (reset) begin
            mon_busy = 1'b0;
            mon_pc   = 0;
            gap      = 100;
        end else begin
            if (!mon_busy) begin
                if (ser_out === 1'b0) begin
                    check("inter_frame_gap", 32'(gap >= 1), 1);
                    check("frame_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    else cur = '{data: 8'h00, pen: 1'b0, podd: 1'b0, two: 1'b0};
                    mon_total = 16 * (2 + 8 + int'(cur.pen) + int'(cur.two));
                    mon_pc = 0;
                    mon_busy = 1'b1;
                    frames_started++;
                end else if (tx_busy === 1'b0) begin
                    gap++;
                end
            end
            if (mon_busy) begin
                if (mon_pc == mon_total) begin
                    check("end_busy", tx_busy, 0);
                    check("end_line", ser_out, 1);
                    $display("frame data=%02h pen=%0b podd=%0b two=%0b pulses=%0d", cur.data,
                             cur.pen, cur.podd, cur.two, mon_total);
                    mon_busy = 1'b0;
                    gap = 1;
                    frames_done++;
                end else begin
                    if (ce_16 && (mon_pc % 16 == 8)) begin
                        check($sformatf("bit%0d_d%02h", mon_pc / 16, cur.data), ser_out,
                              32'(bit_at(cur, mon_pc / 16)));
                        check("busy_mid", tx_busy, 1);
                    end
                    if (ce_16 && mon_pc == mon_total - 1) check("busy_last", tx_busy, 1);
                    if (ce_16) mon_pc++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic pen, input logic podd, input logic two);
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < 5000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("send_ready", tx_busy, 0);
        tx_data = d;
        parity_en = pen;
        parity_odd = podd;
        two_stop = two;
        new_tx_data = 1'b1;
        exp_q.push_back('{data: d, pen: pen, podd: podd, two: two});
        @(posedge clock);
        #1;
        new_tx_data = 1'b0;
        tx_data = 8'($urandom);
        parity_en = 1'($urandom);
        parity_odd = 1'($urandom);
        two_stop = 1'($urandom);
        check("busy_rise", tx_busy, 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(tx_busy === 1'b0 && !mon_busy && exp_q.size() == 0) && n < 20000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("frame_complete", 32'(n < 20000), 1);
    endtask

    initial begin
        int bad;
        int n;
        int base;

        repeat (3) @(posedge clock);
        #1;
        check("reset_ser", ser_out, 1);
        check("reset_busy", tx_busy, 0);
        reset = 1'b0;

        bad = 0;
        repeat (1000) begin
            @(negedge clock);
            if (ser_out !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("idle_1000", bad, 0);
        check("idle_no_frame", frames_started, 0);

        @(posedge clock);
        #1;
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        wait_done();
        check("frames_8n1", frames_done, 1);

        send(8'h03, 1'b1, 1'b0, 1'b0);
        wait_done();
        send(8'h03, 1'b1, 1'b1, 1'b0);
        wait_done();
        send(8'h07, 1'b1, 1'b0, 1'b0);
        wait_done();
        check("frames_parity", frames_done, 4);

        // Mid-frame request must be dropped
        send(8'h55, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (mon_pc < 80 && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("reach_midframe", 32'(mon_pc >= 80), 1);
        tx_data = 8'hFF;
        new_tx_data = 1'b1;
        @(posedge clock);
        #1;
        new_tx_data = 1'b0;
        wait_done();
        repeat (300) @(posedge clock);
        #1;
        check("dropped_request", frames_started, 5);
        check("frames_2stop", frames_done, 5);

        // Request held high: frames back to back
        base = frames_started;
        repeat (3) exp_q.push_back('{data: 8'h81, pen: 1'b0, podd: 1'b0, two: 1'b0});
        tx_data = 8'h81;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        two_stop = 1'b0;
        new_tx_data = 1'b1;
        n = 0;
        while (frames_started < base + 3 && n < 10000) begin
            @(posedge clock);
            #1;
            n++;
        end
        new_tx_data = 1'b0;
        check("held_started", frames_started, base + 3);
        wait_done();
        check("held_done", frames_done, base + 3);

        // Async reset during data bit 3
        send(8'h00, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (mon_pc < 70 && n < 2000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("reach_bit3", 32'(mon_pc >= 70), 1);
        check("bit3_busy", tx_busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_ser", ser_out, 1);
        check("async_busy", tx_busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        base = frames_done;
        send(8'h3C, 1'b0, 1'b0, 1'b0);
        wait_done();
        check("post_reset_frame", frames_done, base + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_ser.md
Name: uart_tx_ser

Overview:
UART serial transmitter clocked by the system clock and paced by the ce_16 enable (16x baud) from the shared baud rate generator. It accepts one parallel word per handshake and serializes it LSB first as start, data, optional parity and 1 or 2 stop bits. It is the transmit end of the UART peripheral and drives the chip TX pad.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..8

Ports:
clock  input  1  global clock
reset  input  1  global reset; asynchronous, active-high
ce_16  input  1  single-cycle enable at 16x baud rate, from the baud generator
tx_data  input  DATA_W  word to transmit; sampled on acceptance
new_tx_data  input  1  request strobe; accepted only when tx_busy=0
parity_en  input  1  1 = append parity bit; sampled on acceptance
parity_odd  input  1  1 = odd parity, 0 = even; sampled on acceptance
two_stop  input  1  1 = two stop bits, 0 = one; sampled on acceptance
tx_busy  output  1  frame in progress; registered
ser_out  output  1  serial line, idle high; registered

Behaviour:
- Reset (async, any time including mid-frame): ser_out=1, tx_busy=0, state IDLE, cnt16=0, shift register=0. The line returns high immediately; no partial-frame recovery.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: at a clock edge with new_tx_data=1 and tx_busy=0 (current registered value).
  - Latch tx_data, parity_en, parity_odd and two_stop.
  - Next-state values: tx_busy=1, ser_out=0, state START, cnt16=0, bitcnt=0.
  - ce_16 on the acceptance edge is not counted.
- new_tx_data while tx_busy=1 is ignored. The word is dropped and no error is flagged.
- Bit timing: in any non-IDLE state, each edge with ce_16=1 increments 4-bit cnt16. On the edge where cnt16==15 and ce_16=1, cnt16 wraps to 0 and the block advances to the next bit, updating ser_out on that same edge. Each bit lasts exactly 16 ce_16 pulses.
- Cycles with ce_16=0 hold all state.
- Transitions:
  - START -> DATA: ser_out=bit0.
  - DATA: bitcnt increments per bit. After bit DATA_W-1, go to PARITY if parity_en, else STOP.
  - PARITY: ser_out = XOR(data) XOR parity_odd.
  - STOP: ser_out=1 for 16 pulses, or 32 pulses if two_stop.
- Frame end: on the edge ending the last stop bit, state IDLE and tx_busy=0. ser_out stays 1.
- Back-to-back: a request asserted on the same edge that tx_busy falls is not accepted, because the registered tx_busy is still 1. It is accepted one clock later. Minimum gap between frames is therefore one clock plus the ce_16 phase.
- Frame length in ce_16 pulses: 16*(1 + DATA_W + parity_en + 1 + two_stop). Examples: 8N1 = 160, 8E2 = 192.
- The latched config ignores input changes mid-frame.
- tx_data must only be valid in the acceptance cycle.

Test Plan:
- Reset, then idle with ce_16 toggling -> ser_out=1 and tx_busy=0 for 1000 clocks.
- ce_16 every 4 clocks; send 0xA5 with 8N1 -> tx_busy rises the next clock. Line reads 0, 1,0,1,0,0,1,0,1, 1, each bit 16 ce_16 pulses = 64 clocks. tx_busy falls after 160 pulses.
- Send 0x03 with parity_en=1, parity_odd=0 -> parity bit 0. Send 0x03 with parity_odd=1 -> parity bit 1. Send 0x07 with even parity -> parity bit 1.
- Send 0x55 with two_stop=1, then pulse new_tx_data=0xFF at mid-frame -> second request dropped. Stop high for 32 pulses, frame = 176 pulses, no second frame.
- Hold new_tx_data=1 continuously with 0x81 -> consecutive frames separated by at least one idle clock. Each frame is decoded correctly by the bench UART model at the matching baud rate.
- Assert reset during data bit 3 of 0x00 -> ser_out=1 and tx_busy=0 immediately (asynchronous). After release, a fresh 0x3C frame transmits correctly.
